// File: rtl/therm_pkg.sv
// Shared definitions for the thermometer encode/decode blocks: default widths,
// a constant log2 helper and the count-to-thermometer decode function.
package therm_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 3;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Bit i of the pattern is set iff the count exceeds i.
  function automatic logic [OUT_W-1:0] therm_decode(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 32'sd0; i < OUT_W; i++) begin
      r[i] = (int'(code) > i);
    end
    return r;
  endfunction

endpackage

// File: rtl/therm_decoder_stream_sync_fifo.sv
// Small synchronous FIFO with occupancy count. push/pop requests are qualified
// internally against full/empty, so callers may hold requests asserted.
import therm_pkg::*;

module sync_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   fill
);

  localparam int AW     = clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1'b1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1'b1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [W-1:0]      mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (fill_r == FILL_MAX);
  assign empty     = (fill_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign fill      = fill_r;

  // Storage is deliberately not reset; fill=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/therm_decoder_stream.sv
// Streaming count-code to thermometer decoder: codes are buffered in a FIFO,
// decoded at the FIFO head and counted as they are delivered downstream.
import therm_pkg::*;

module therm_decoder_stream #(
  parameter int CODE_W = therm_pkg::CODE_W,
  parameter int OUT_W  = therm_pkg::OUT_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_W-1:0]     in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_therm,
  output logic [CNT_W-1:0]      txn_cnt,
  output logic [clog2(DEPTH):0] fill
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CODE_W-1:0] head_code_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  txn_cnt_r;

  sync_fifo #(
    .W     (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (out_ready),
    .din   (in_code),
    .dout  (head_code_s),
    .full  (full_s),
    .empty (empty_s),
    .fill  (fill)
  );

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign txn_cnt   = txn_cnt_r;

  // Gate the head entry so an empty FIFO never exposes stale or unknown data.
  always_comb begin
    out_therm = '0;
    if (!empty_s) begin
      out_therm = therm_decode(head_code_s);
    end else begin
      out_therm = '0;
    end
  end

  // Delivered-transaction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt_r <= '0;
    end else if (out_valid && out_ready) begin
      txn_cnt_r <= txn_cnt_r + CNT_ONE;
    end else begin
      txn_cnt_r <= txn_cnt_r;
    end
  end

endmodule

// File: tb/tb_therm_decoder_stream.sv
// Self-checking bench for therm_decoder_stream: directed phases with random
// codes, compared every cycle against a queue-based reference model.
module tb_therm_decoder_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_therm;
  logic [7:0] txn_cnt;
  logic [2:0] fill;

  int checks;
  int failures;
  int model_q[$];
  int model_cnt;

  therm_decoder_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_therm (out_therm),
    .txn_cnt   (txn_cnt),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A count c maps to c low-order ones.
  function automatic logic [2:0] ref_therm(input int c);
    return 3'((1 << c) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, apply one clock edge, update the model.
  task automatic step(input logic v, input logic [1:0] c, input logic r, output logic acc);
    logic do_push;
    logic do_pop;
    int   n;
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    #1;
    n = model_q.size();
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready",  32'(in_ready),  32'(n != 4));
    chk("fill",      32'(fill),      32'(n));
    chk("out_therm", 32'(out_therm), 32'((n != 0) ? ref_therm(model_q[0]) : 3'b000));
    chk("txn_cnt",   32'(txn_cnt),   32'(model_cnt % 256));
    do_push = v && (n < 4);
    do_pop  = r && (n > 0);
    @(posedge clk);
    if (do_pop) begin
      void'(model_q.pop_front());
      model_cnt++;
    end
    if (do_push) model_q.push_back(int'(c));
    acc = do_push;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    model_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       acc;
    logic       hold;
    logic [2:0] saved_therm;
    logic [7:0] saved_cnt;
    int         guard;
    checks = 0; failures = 0; model_cnt = 0;
    in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_therm", 32'(out_therm), 32'd0);
    chk("rst_txn", 32'(txn_cnt), 32'd0);

    // decode table, one code per cycle
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1, acc);
    step(1'b0, 2'd0, 1'b1, acc);
    chk("table_txn4", 32'(txn_cnt), 32'd4);

    // fill to full with a stalled sink, then drain
    step(1'b1, 2'd3, 1'b0, acc);
    step(1'b1, 2'd2, 1'b0, acc);
    step(1'b1, 2'd1, 1'b0, acc);
    step(1'b1, 2'd0, 1'b0, acc);
    step(1'b1, 2'd3, 1'b0, acc);
    chk("full_fill", 32'(fill), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_held", 32'(acc), 32'd0);
    hold = 1'b1; guard = 0;
    while (hold && guard < 10) begin
      step(1'b1, 2'd3, 1'b1, acc);
      if (acc) hold = 1'b0;
      guard++;
    end
    chk("held_accepted", 32'(hold), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b1, acc);
    chk("full_drained_txn", 32'(txn_cnt), 32'd9);

    // continuous streaming: fill stays at one
    step(1'b1, 2'($urandom_range(3, 0)), 1'b1, acc);
    for (int i = 0; i < 20; i++) begin
      chk("stream_fill1", 32'(fill), 32'd1);
      step(1'b1, 2'($urandom_range(3, 0)), 1'b1, acc);
    end
    step(1'b0, 2'd0, 1'b1, acc);

    // stall with valid data held
    step(1'b1, 2'($urandom_range(3, 1)), 1'b0, acc);
    saved_therm = out_therm;
    saved_cnt   = txn_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, acc);
    chk("stall_therm", 32'(out_therm), 32'(saved_therm));
    chk("stall_txn", 32'(txn_cnt), 32'(saved_cnt));
    step(1'b0, 2'd0, 1'b1, acc);

    // random mixed traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), acc);

    // counter wrap after 260 handshakes
    do_reset();
    guard = 0;
    while (model_cnt < 260 && guard < 400) begin
      step(1'b1, 2'($urandom_range(3, 0)), 1'($urandom_range(3, 0) != 0), acc);
      guard++;
    end
    chk("wrap_reached", 32'(model_cnt), 32'd260);
    chk("wrap_txn4", 32'(txn_cnt), 32'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, acc);

    // reset mid-stream with three codes buffered
    for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom_range(3, 0)), 1'b0, acc);
    chk("mid_fill3", 32'(fill), 32'd3);
    do_reset();
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_therm", 32'(out_therm), 32'd0);
    chk("mid_fill", 32'(fill), 32'd0);
    chk("mid_txn", 32'(txn_cnt), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 2'd2, 1'b0, acc);
    #1;
    chk("mid_fresh_therm", 32'(out_therm), 32'(3'b011));
    step(1'b0, 2'd0, 1'b1, acc);
    step(1'b0, 2'd0, 1'b1, acc);
    chk("mid_fresh_txn", 32'(txn_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/therm_decoder_stream.md
Name: therm_decoder_stream

Overview:
- Streaming decoder that turns a 2-bit count code into a 3-bit thermometer pattern. It is the inverse of the 3-in/2-out ones-count encoder already in the design.
- Codes enter through a valid/ready port and are buffered in a small synchronous FIFO. Decoded patterns leave through a second valid/ready port.
- It is used to regenerate thermometer-coded control words from compact counts on the receive side of a block boundary.

Parameters:
- CODE_W, 2, width of input count code.
- OUT_W, 3, thermometer width. Must equal 2**CODE_W-1.
- DEPTH, 4, FIFO entries. Power of two, minimum 2.
- CNT_W, 8, width of the delivered-transaction counter.

Ports:
- clk  input  1  single clock. All logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  CODE_W  count to decode, range 0..OUT_W.
- out_valid  output  1  out_therm is valid.
- out_ready  input  1  downstream accepts out_therm this cycle.
- out_therm  output  OUT_W  thermometer pattern. Bit i = 1 iff code > i.
- txn_cnt  output  CNT_W  number of completed output handshakes, wrapping.
- fill  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Sampled on the clk edge when rst_n=0.
  - Clears wr_ptr, rd_ptr and fill, so fill=0, out_valid=0, out_therm=0, txn_cnt=0, in_ready=1 on the first cycle after the reset edge.
  - FIFO memory contents are not cleared; they are unreachable because fill=0.
- Push: occurs when in_valid && in_ready at a clk edge. Writes in_code to mem[wr_ptr], then wr_ptr increments.
- Pop: occurs when out_valid && out_ready at a clk edge. rd_ptr increments and txn_cnt increments.
- Decode table:
  - 0 -> 000
  - 1 -> 001
  - 2 -> 011
  - 3 -> 111
- Output data:
  - out_therm = decode(mem[rd_ptr]) when fill>0.
  - out_therm = 0 when fill=0. No X is allowed on the output.
- Latency: a code pushed at edge N appears on out_therm, with out_valid=1, after edge N, when the FIFO was empty. There is no combinational in->out bypass.
- Ordering: strict FIFO order. No drops and no duplicates.
- Flags:
  - in_ready = (fill != DEPTH).
  - out_valid = (fill != 0).
  - Neither flag depends combinationally on in_valid or out_ready.
- Full (fill=DEPTH):
  - in_ready=0, even if a pop happens in the same cycle.
  - A presented code is held by the upstream and accepted on a later cycle.
- Empty (fill=0): out_valid=0, and out_ready is ignored.
- Simultaneous push and pop with 0<fill<DEPTH: fill is unchanged and both pointers advance.
- Wrap-around:
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
  - txn_cnt wraps from 2**CNT_W-1 to 0 without any flag.
- Stability: while out_valid=1 and out_ready=0, out_therm is held stable.
- Reset mid-operation: all buffered codes are discarded. The output is 0/invalid on the next cycle, and txn_cnt restarts at 0.
- Width rule: the input range 0..OUT_W is fully covered when OUT_W=2**CODE_W-1, so no out-of-range codes exist.

Decomposition:
- Shared package therm_pkg holds:
  - the CODE_W and OUT_W defaults
  - the constant function clog2
  - the function therm_decode(code), which returns an OUT_W-bit pattern with bit i = (code > i).
- The encoder bench reuses therm_decode as its reference model.
- One sub-module, sync_fifo. It is parameterised on width and depth and exposes push, pop, full, empty, dout and fill.
- therm_decoder_stream instantiates sync_fifo and adds the decode, the output gating and txn_cnt.

Test Plan:
- Reset, then push codes 0,1,2,3 one per cycle with out_ready=1. Expect out_therm=000,001,011,111, each one cycle after its push, and txn_cnt=4.
- Hold out_ready=0 and push 5 codes (3,2,1,0,3) with DEPTH=4. Expect fill=4 and in_ready=0 after the 4th push, and the 5th code held by the upstream. Then set out_ready=1: expect outputs 111,011,001,000, followed by 111 after the 5th code is accepted.
- Continuous push and pop at 100% duty for 20 cycles with random codes. Expect fill constant at 1, out_therm matching therm_decode in order, and no bubbles.
- Stall check: with out_valid=1, drop out_ready for 3 cycles. Expect out_therm unchanged and txn_cnt unchanged.
- Wrap-around: 260 transfers with CNT_W=8. Expect txn_cnt=4 after the 260th handshake, and pointer wrap at every 4th entry with order preserved.
- Reset mid-stream: pull rst_n low for one cycle while fill=3. Expect out_valid=0, out_therm=000, fill=0, txn_cnt=0 and in_ready=1 on the next cycle, and no stale code appearing after the next push.
